// File: rtl/cordic_sweep_nco_if.sv
// Control/config and sample bus between the sweep NCO and whoever drives it.
interface cordic_sweep_nco_if #(
  parameter int PW = 24,
  parameter int AW = 10
);
  logic          cfg_wr;
  logic [1:0]    cfg_addr;
  logic [PW-1:0] cfg_data;
  logic          start;
  logic          stop;
  logic [AW-1:0] ang;
  logic          ang_vld;
  logic          cordic_vld;
  logic          busy;
  logic          done;
  logic [PW-1:0] cur_freq;

  modport master (
    output cfg_wr, cfg_addr, cfg_data, start, stop,
    input  ang, ang_vld, cordic_vld, busy, done, cur_freq
  );

  modport slave (
    input  cfg_wr, cfg_addr, cfg_data, start, stop,
    output ang, ang_vld, cordic_vld, busy, done, cur_freq
  );
endinterface

// File: rtl/cordic_sweep_nco.sv
// Chirp NCO feeding the pipelined CORDIC rotator angle input, with a latency-matched valid.
// Optional phase dither on the output angle: define CORDIC_NCO_DITHER_EN.
module cordic_sweep_nco #(
  parameter int PW  = 24,
  parameter int AW  = 10,
  parameter int LAT = 11,
  parameter int DWW = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  cordic_sweep_nco_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state;
  logic [PW-1:0]  f_start, f_stop, f_step;
  logic [DWW-1:0] dwell, dwell_cnt;
  logic [PW-1:0]  phase, cur_freq;
  logic [LAT-1:0] vpipe;
  logic [AW-1:0]  ang_q, ang_next;
  logic           ang_vld_q, done_q;
  logic [PW:0]    next_sum;
  logic           step_end;

`ifdef CORDIC_NCO_DITHER_EN
  logic [15:0] lfsr;
  logic        dith_c;

  always_ff @(posedge clk) begin
    if (!rst_n)  lfsr <= 16'hACE1;
    else if (en) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Only the carry out of the fractional bits matters for the truncated angle.
  assign dith_c   = (phase[PW-AW-1:0] + lfsr[PW-AW-1:0]) < phase[PW-AW-1:0];
  assign ang_next = phase[PW-1 -: AW] + AW'(dith_c);
`else
  assign ang_next = phase[PW-1 -: AW];
`endif

  // Extra carry bit: an unsigned wrap counts as overshoot (up) or borrow (down).
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    step_end = 1'b0;
    next_sum = {1'b0, cur_freq} + {1'b0, f_step};
    if (f_step[PW-1]) step_end = !next_sum[PW] || (next_sum[PW-1:0] < f_stop);
    else              step_end =  next_sum[PW] || (next_sum[PW-1:0] > f_stop);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      f_start   <= '0;
      f_stop    <= '0;
      f_step    <= '0;
      dwell     <= '0;
      dwell_cnt <= '0;
      phase     <= '0;
      cur_freq  <= '0;
      vpipe     <= '0;
      ang_q     <= '0;
      ang_vld_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      if (bus.cfg_wr && state != S_RUN) begin
        case (bus.cfg_addr)
          2'd0:    f_start <= bus.cfg_data;
          2'd1:    f_stop  <= bus.cfg_data;
          2'd2:    f_step  <= bus.cfg_data;
          default: dwell   <= bus.cfg_data[DWW-1:0];
        endcase
      end

      if (en) vpipe <= {vpipe[LAT-2:0], ang_vld_q};

      if (bus.stop) begin
        state     <= S_IDLE;
        ang_vld_q <= 1'b0;
      end else if (bus.start && state != S_RUN) begin
        phase     <= '0;
        cur_freq  <= f_start;
        dwell_cnt <= dwell;
        done_q    <= 1'b0;
        ang_vld_q <= 1'b0;
        state     <= S_RUN;
      end else if (en) begin
        if (state == S_RUN) begin
          ang_q     <= ang_next;
          ang_vld_q <= 1'b1;
          phase     <= phase + cur_freq;
          if (dwell_cnt == '0) begin
            dwell_cnt <= dwell;
            // A zero step is a continuous tone: frequency never moves, sweep never ends.
            if (f_step != '0) begin
              if (step_end) begin
                state  <= S_DONE;
                done_q <= 1'b1;
              end else begin
                cur_freq <= next_sum[PW-1:0];
              end
            end
          end else begin
            dwell_cnt <= dwell_cnt - DWW'(1);
          end
        end else begin
          ang_vld_q <= 1'b0;
        end
      end
    end
  end

  assign bus.ang        = ang_q;
  assign bus.ang_vld    = ang_vld_q;
  assign bus.cordic_vld = vpipe[LAT-1];
  assign bus.busy       = (state == S_RUN);
  assign bus.done       = done_q;
  assign bus.cur_freq   = cur_freq;

endmodule

// File: tb/tb_cordic_sweep_nco.sv
// Directed bench for cordic_sweep_nco: expected angles are queued by a sweep model and popped per live sample.
module tb_cordic_sweep_nco;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  cordic_sweep_nco_if #(.PW(24), .AW(10)) bus ();

  cordic_sweep_nco #(.PW(24), .AW(10), .LAT(11), .DWW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .bus   (bus)
  );

  int vectors = 0;
  int errs    = 0;

  logic [9:0] exp_q[$];
  logic [9:0] last_exp;
  bit         mon_on;
  int         nseen;
  int         en_cnt = 0;
  int         vld_first, vld_last, cv_first, cv_last;
  bit         seen_v, seen_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; on enabled edges log valid timing and score live samples.
  task automatic tick(input logic e);
    en = e;
    @(posedge clk);
    #1;
    if (e) begin
      en_cnt++;
      if (bus.ang_vld) begin
        if (!seen_v) begin vld_first = en_cnt; seen_v = 1'b1; end
        vld_last = en_cnt;
        if (mon_on) begin
          if (exp_q.size() == 0) chk("extra_sample", bus.ang, 32'hFFFF_FFFF);
          else begin
            last_exp = exp_q.pop_front();
            nseen++;
            chk("ang", bus.ang, last_exp);
          end
        end
      end
      if (bus.cordic_vld) begin
        if (!seen_c) begin cv_first = en_cnt; seen_c = 1'b1; end
        cv_last = en_cnt;
      end
    end
  endtask

  task automatic cfg(input logic [1:0] a, input logic [23:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_addr = a; bus.cfg_data = d;
    tick(1'b0);
    bus.cfg_wr = 1'b0;
  endtask

  task automatic cfg_all(input logic [23:0] fs, fe, fstep, input logic [15:0] dw);
    cfg(2'd0, fs); cfg(2'd1, fe); cfg(2'd2, fstep); cfg(2'd3, {8'h00, dw});
  endtask

  task automatic pulse_start();
    bus.start = 1'b1; tick(1'b1); bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1; tick(1'b1); bus.stop = 1'b0;
  endtask

  // Drain the valid pipe while idle and clear the timing marks.
  task automatic flush();
    for (int i = 0; i < 12; i++) tick(1'b1);
    seen_v = 1'b0; seen_c = 1'b0; nseen = 0;
    exp_q.delete();
  endtask

  // Reference sweep: samples per frequency = dwell+1, signed step against f_stop.
  task automatic push_sweep(input logic [23:0] fs, fe, fstep, input int dw, input int nmax);
    logic [23:0] ph;
    longint f, nf, st;
    int n;
    bit fin;
    ph = '0; f = longint'(fs); st = longint'($signed(fstep)); n = 0; fin = 1'b0;
    while (!fin && n < nmax) begin
      for (int k = 0; k <= dw && n < nmax; k++) begin
        exp_q.push_back(ph[23:14]);
        ph = ph + f[23:0];
        n++;
      end
      if (st != 0) begin
        nf = f + st;
        if ((st > 0 && nf > longint'(fe)) || (st < 0 && nf < longint'(fe))) fin = 1'b1;
        else f = nf;
      end
    end
  endtask

  task automatic sweep_test(input string tag, input logic [23:0] fs, fe, fstep,
                            input logic [15:0] dw, input bit gate);
    cfg_all(fs, fe, fstep, dw);
    flush();
    mon_on = 1'b1;
    push_sweep(fs, fe, fstep, int'(dw), 64);
    pulse_start();
    for (int i = 0; i < 300 && !bus.done; i++) begin
      tick(gate ? logic'(i % 2 == 1) : 1'b1);
      if (gate && en == 1'b0 && nseen > 0) chk({tag, "_frozen_ang"}, bus.ang, last_exp);
    end
    chk({tag, "_drained"}, exp_q.size(), 0);
    chk({tag, "_done"}, bus.done, 1'b1);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    tick(1'b1);
    chk({tag, "_vld_off"}, bus.ang_vld, 1'b0);
    for (int i = 0; i < 40; i++) tick(gate ? logic'(i % 2 == 1) : 1'b1);
    chk({tag, "_cv_rise"}, cv_first - vld_first, 11);
    chk({tag, "_cv_tail"}, cv_last - vld_last, 11);
    mon_on = 1'b0;
  endtask

  initial begin
    bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.start = 1'b0; bus.stop = 1'b0;
    mon_on = 1'b0; nseen = 0; last_exp = '0;
    seen_v = 1'b0; seen_c = 1'b0;
    vld_first = 0; vld_last = 0; cv_first = 0; cv_last = 0;
    rst_n = 1'b0;
    tick(1'b1); tick(1'b1);
    chk("rst_ang", bus.ang, 0);
    chk("rst_ang_vld", bus.ang_vld, 0);
    chk("rst_cordic_vld", bus.cordic_vld, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cur_freq", bus.cur_freq, 0);
    rst_n = 1'b1;

    // CW tone, 257 samples to show the wrap back to 0.
    cfg_all(24'h010000, 24'h000000, 24'h000000, 16'd0);
    flush();
    mon_on = 1'b1;
    push_sweep(24'h010000, 24'h000000, 24'h000000, 0, 257);
    pulse_start();
    chk("cw_busy", bus.busy, 1);
    chk("cw_vld_not_yet", bus.ang_vld, 0);
    tick(1'b1);
    chk("cw_vld_2nd_edge", bus.ang_vld, 1);
    for (int i = 0; i < 400 && exp_q.size() > 0; i++) tick(1'b1);
    chk("cw_drained", exp_q.size(), 0);
    chk("cw_cv_rise", cv_first - vld_first, 11);
    mon_on = 1'b0;
    pulse_stop();
    chk("stop_busy", bus.busy, 0);
    chk("stop_done", bus.done, 0);
    chk("stop_vld", bus.ang_vld, 0);

    sweep_test("up",   24'h004000, 24'h00C000, 24'h004000, 16'd3, 1'b0);
    sweep_test("down", 24'h00C000, 24'h004000, 24'hFFC000, 16'd1, 1'b0);
    sweep_test("gate", 24'h004000, 24'h00C000, 24'h004000, 16'd3, 1'b1);

    // Stop from DONE leaves done alone; start+stop together from IDLE stays idle.
    pulse_stop();
    chk("stop_in_done_done", bus.done, 1);
    bus.start = 1'b1; bus.stop = 1'b1;
    tick(1'b1);
    bus.start = 1'b0; bus.stop = 1'b0;
    chk("start_stop_busy", bus.busy, 0);

    // f_start write while busy must not reach the next start.
    cfg_all(24'h004000, 24'h000000, 24'h000000, 16'd0);
    pulse_start();
    tick(1'b1); tick(1'b1);
    cfg(2'd0, 24'h010000);
    pulse_stop();
    flush();
    mon_on = 1'b1;
    push_sweep(24'h004000, 24'h000000, 24'h000000, 0, 8);
    pulse_start();
    chk("busy_wr_freq", bus.cur_freq, 24'h004000);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(1'b1);
    chk("busy_wr_drained", exp_q.size(), 0);
    mon_on = 1'b0;
    pulse_stop();

    // Reset mid-sweep clears everything including configuration.
    cfg_all(24'h004000, 24'h00C000, 24'h004000, 16'd3);
    pulse_start();
    for (int i = 0; i < 5; i++) tick(1'b1);
    rst_n = 1'b0;
    tick(1'b1);
    rst_n = 1'b1;
    chk("mid_rst_ang", bus.ang, 0);
    chk("mid_rst_ang_vld", bus.ang_vld, 0);
    chk("mid_rst_cordic_vld", bus.cordic_vld, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_cur_freq", bus.cur_freq, 0);
    flush();
    mon_on = 1'b1;
    push_sweep(24'h000000, 24'h000000, 24'h000000, 0, 20);
    pulse_start();
    chk("post_rst_busy", bus.busy, 1);
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(1'b1);
    chk("post_rst_drained", exp_q.size(), 0);
    chk("post_rst_freq", bus.cur_freq, 0);
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
